// File: rtl/fft_1024_addr_gen.sv
// rtl/fft_1024_addr_gen.sv - radix-2 DIT address generator for a 1024-point in-place FFT
module fft_1024_addr_gen (
   input  logic       clock_c,
   input  logic       reset_n,
   input  logic       start,
   input  logic       en,
   input  logic [8:0] bfly_idx,
   input  logic       bfly_last,
   output logic [9:0] addr_a,
   output logic [9:0] addr_b,
   output logic [8:0] tw_addr,
   output logic [3:0] stage,
   output logic       busy,
   output logic       addr_valid,
   output logic       xfm_done
);

   localparam logic [3:0] LAST_STAGE = 4'd9;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [3:0]  stage_nx;
   logic        load;
   logic        done_nx;

   logic [9:0]  idx_ext;
   logic [9:0]  low_mask;
   logic [9:0]  a_calc;
   logic [9:0]  b_calc;
   logic [8:0]  pos;
   logic [17:0] tw_wide;

   // Butterfly operand/twiddle addresses for (stage, bfly_idx): a zero bit
   // is spliced in at bit position 'stage' for the upper operand, a one bit
   // for the lower; the twiddle index is the in-group position scaled up.
   always_comb begin
      idx_ext  = {1'b0, bfly_idx};
      low_mask = (10'd1 << stage) - 10'd1;
      a_calc   = ((idx_ext & ~low_mask) << 1) | (idx_ext & low_mask);
      b_calc   = a_calc | (10'd1 << stage);
      pos      = bfly_idx & low_mask[8:0];
      tw_wide  = {9'd0, pos} << (LAST_STAGE - stage);
   end

   // Next-state logic: start wins over everything, then en qualifies a
   // butterfly, and bfly_last on the final stage closes the transform.
   always_comb begin
      state_nx = state;
      stage_nx = stage;
      load     = 1'b0;
      done_nx  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_RUN;
               stage_nx = 4'd0;
            end
         end
         S_RUN: begin
            if (start) begin
               stage_nx = 4'd0;
            end else if (en) begin
               load = 1'b1;
               if (bfly_last) begin
                  if (stage == LAST_STAGE) begin
                     state_nx = S_IDLE;
                     stage_nx = 4'd0;
                     done_nx  = 1'b1;
                  end else begin
                     stage_nx = stage + 4'd1;
                  end
               end
            end
         end
         default: begin
            state_nx = S_IDLE;
            stage_nx = 4'd0;
         end
      endcase
   end

   // State, stage and status flags; busy is a flop so it never sees inputs
   // combinationally.
   always_ff @(posedge clock_c or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         stage      <= 4'd0;
         busy       <= 1'b0;
         addr_valid <= 1'b0;
         xfm_done   <= 1'b0;
      end else begin
         state      <= state_nx;
         stage      <= stage_nx;
         busy       <= (state_nx == S_RUN);
         addr_valid <= load;
         xfm_done   <= done_nx;
      end
   end

   // Address registers only move on a qualified butterfly and otherwise hold.
   always_ff @(posedge clock_c or negedge reset_n) begin
      if (!reset_n) begin
         addr_a  <= 10'd0;
         addr_b  <= 10'd0;
         tw_addr <= 9'd0;
      end else if (load) begin
         addr_a  <= a_calc;
         addr_b  <= b_calc;
         tw_addr <= tw_wide[8:0];
      end
   end

endmodule

// File: tb/tb_fft_1024_addr_gen.sv
// tb/tb_fft_1024_addr_gen.sv - self-checking bench for fft_1024_addr_gen
module tb_fft_1024_addr_gen;

   logic       clock_c = 1'b0;
   logic       reset_n = 1'b1;
   logic       start = 1'b0;
   logic       en = 1'b0;
   logic [8:0] bfly_idx = 9'd0;
   logic       bfly_last = 1'b0;
   logic [9:0] addr_a;
   logic [9:0] addr_b;
   logic [8:0] tw_addr;
   logic [3:0] stage;
   logic       busy;
   logic       addr_valid;
   logic       xfm_done;

   fft_1024_addr_gen dut (
      .clock_c   (clock_c),
      .reset_n   (reset_n),
      .start     (start),
      .en        (en),
      .bfly_idx  (bfly_idx),
      .bfly_last (bfly_last),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .tw_addr   (tw_addr),
      .stage     (stage),
      .busy      (busy),
      .addr_valid(addr_valid),
      .xfm_done  (xfm_done)
   );

   always #5 clock_c = ~clock_c;

   typedef struct {
      logic [9:0] a;
      logic [9:0] b;
      logic [8:0] tw;
      logic       done;
      int         s;
   } exp_t;

   typedef struct {
      int s;
      int j;
      int a;
      int b;
      int tw;
   } vec_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          dup_cnt = 0;
   logic        m_run = 1'b0;
   int          m_stage = 0;
   logic [9:0]  last_a = '0;
   logic [9:0]  last_b = '0;
   logic [8:0]  last_tw = '0;
   logic [1023:0] seen [10];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_addr(input int s, input int j, output logic [9:0] a,
                             output logic [9:0] b, output logic [8:0] tw);
      int pos, grp, av;
      pos = j % (1 << s);
      grp = j >> s;
      av  = (grp << (s + 1)) | pos;
      a   = av[9:0];
      av  = av + (1 << s);
      b   = av[9:0];
      av  = (pos << (9 - s)) & 511;
      tw  = av[8:0];
   endtask

   task automatic step(input logic st, input logic e, input logic [8:0] j, input logic l);
      exp_t x;
      logic v;
      x = '{a: '0, b: '0, tw: '0, done: 1'b0, s: 0};
      @(negedge clock_c);
      start = st; en = e; bfly_idx = j; bfly_last = l;
      v = m_run && e && !st;
      if (v) begin
         model_addr(m_stage, int'(j), x.a, x.b, x.tw);
         x.done = l && (m_stage == 9);
         x.s    = m_stage;
         q.push_back(x);
      end
      if (st) begin
         m_run = 1'b1; m_stage = 0;
      end else if (m_run && e && l) begin
         if (m_stage == 9) begin
            m_run = 1'b0; m_stage = 0;
         end else begin
            m_stage++;
         end
      end
      @(posedge clock_c);
      #1;
      chk("addr_valid", int'(addr_valid), int'(v));
      x.done = 1'b0;
      if (v && q.size() > 0) begin
         x = q.pop_front();
         last_a = x.a; last_b = x.b; last_tw = x.tw;
         if (seen[x.s][x.a] || seen[x.s][x.b]) dup_cnt++;
         seen[x.s][x.a] = 1'b1;
         seen[x.s][x.b] = 1'b1;
      end
      chk("addr_a", int'(addr_a), int'(last_a));
      chk("addr_b", int'(addr_b), int'(last_b));
      chk("tw_addr", int'(tw_addr), int'(last_tw));
      chk("xfm_done", int'(xfm_done), int'(x.done));
      chk("busy", int'(busy), int'(m_run));
      chk("stage", int'(stage), m_stage);
      if (xfm_done) done_cnt++;
   endtask

   task automatic do_reset();
      @(posedge clock_c);
      #3;
      reset_n = 1'b0;
      start = 0; en = 0; bfly_idx = 0; bfly_last = 0;
      #1;
      chk("rst_addr_a", int'(addr_a), 0);
      chk("rst_addr_b", int'(addr_b), 0);
      chk("rst_tw_addr", int'(tw_addr), 0);
      chk("rst_stage", int'(stage), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_addr_valid", int'(addr_valid), 0);
      chk("rst_xfm_done", int'(xfm_done), 0);
      m_run = 1'b0; m_stage = 0;
      last_a = '0; last_b = '0; last_tw = '0;
      q.delete();
      repeat (2) @(negedge clock_c);
      reset_n = 1'b1;
   endtask

   task automatic clear_seen();
      for (int s = 0; s < 10; s++) seen[s] = '0;
      dup_cnt = 0;
   endtask

   task automatic goto_stage(input int s);
      step(1'b1, 1'b0, 9'd0, 1'b0);
      for (int k = 0; k < s; k++) step(1'b0, 1'b1, 9'd511, 1'b1);
   endtask

   initial begin
      vec_t vt[10];
      int   d0;
      vt[0] = '{s: 0, j: 5,   a: 10,  b: 11,   tw: 0};
      vt[1] = '{s: 3, j: 427, a: 851, b: 859,  tw: 192};
      vt[2] = '{s: 1, j: 0,   a: 0,   b: 2,    tw: 0};
      vt[3] = '{s: 1, j: 3,   a: 5,   b: 7,    tw: 256};
      vt[4] = '{s: 2, j: 6,   a: 10,  b: 14,   tw: 256};
      vt[5] = '{s: 5, j: 100, a: 196, b: 228,  tw: 64};
      vt[6] = '{s: 8, j: 511, a: 767, b: 1023, tw: 510};
      vt[7] = '{s: 9, j: 0,   a: 0,   b: 512,  tw: 0};
      vt[8] = '{s: 9, j: 300, a: 300, b: 812,  tw: 300};
      vt[9] = '{s: 0, j: 511, a: 1022, b: 1023, tw: 0};

      clear_seen();
      do_reset();

      // idle ignores en / bfly_last
      step(1'b0, 1'b1, 9'd5, 1'b1);
      step(1'b0, 1'b1, 9'd511, 1'b0);

      // table-driven address vectors
      for (int i = 0; i < 10; i++) begin
         goto_stage(vt[i].s);
         step(1'b0, 1'b1, vt[i].j[8:0], 1'b0);
         chk($sformatf("vec%0d_addr_a", i), int'(addr_a), vt[i].a);
         chk($sformatf("vec%0d_addr_b", i), int'(addr_b), vt[i].b);
         chk($sformatf("vec%0d_tw_addr", i), int'(tw_addr), vt[i].tw);
         chk($sformatf("vec%0d_stage", i), int'(stage), vt[i].s);
         step(1'b0, 1'b0, 9'd1, 1'b1);
      end

      // final butterfly of stage 9
      goto_stage(9);
      d0 = done_cnt;
      step(1'b0, 1'b1, 9'd511, 1'b1);
      chk("last_addr_a", int'(addr_a), 511);
      chk("last_addr_b", int'(addr_b), 1023);
      chk("last_tw_addr", int'(tw_addr), 511);
      chk("last_valid", int'(addr_valid), 1);
      chk("last_done", int'(xfm_done), 1);
      chk("last_busy", int'(busy), 0);
      chk("last_stage", int'(stage), 0);
      step(1'b0, 1'b0, 9'd0, 1'b0);
      chk("last_done_after", int'(xfm_done), 0);
      chk("last_done_count", done_cnt - d0, 1);

      // restart at stage 4
      goto_stage(4);
      d0 = done_cnt;
      step(1'b1, 1'b1, 9'd7, 1'b1);
      chk("restart_stage", int'(stage), 0);
      chk("restart_valid", int'(addr_valid), 0);
      chk("restart_busy", int'(busy), 1);
      step(1'b0, 1'b1, 9'd3, 1'b0);
      chk("restart_done_count", done_cnt - d0, 0);

      // abort by reset at stage 6
      goto_stage(6);
      d0 = done_cnt;
      do_reset();
      step(1'b0, 1'b1, 9'd511, 1'b1);
      step(1'b0, 1'b1, 9'd12, 1'b0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done_count", done_cnt - d0, 0);

      // full transform with en gaps and stray bfly_last while en=0
      clear_seen();
      d0 = done_cnt;
      step(1'b1, 1'b0, 9'd0, 1'b0);
      for (int s = 0; s < 10; s++) begin
         for (int j = 0; j < 512; j++) begin
            if ($urandom_range(7) == 0)
               step(1'b0, 1'b0, 9'($urandom_range(511)), 1'($urandom_range(1)));
            step(1'b0, 1'b1, 9'(j), (j == 511));
         end
      end
      step(1'b0, 1'b0, 9'd0, 1'b0);
      chk("full_done_count", done_cnt - d0, 1);
      chk("full_dup_count", dup_cnt, 0);
      for (int s = 0; s < 10; s++)
         chk($sformatf("full_cover_stage%0d", s), $countones(seen[s]), 1024);
      chk("full_idle", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
